shape_measure: RTL and testbench

SHAPE_MEASURE -- requirements
Module: shape_measure

---
 rtl/shape_pkg.sv | 19 +
 rtl/mask_line_buffer.sv | 27 ++
 rtl/shape_measure.sv | 125 ++++++++++++
 tb/tb_shape_measure.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shape_pkg.sv
// Shared definitions for the shape measurement block: default frame geometry,
// the counter width derivation and the report FSM state encoding.
package shape_pkg;

  localparam int DEFAULT_WIDTH  = 720;
  localparam int DEFAULT_HEIGHT = 1280;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    ISSUE   = 2'd2
  } report_state_t;

  // One spare bit above the pixel count so area never wraps.
  function automatic int calc_cw(input int w, input int h);
    return $clog2(w * h) + 1;
  endfunction

endpackage

// File: rtl/mask_line_buffer.sv
// One-row mask memory: combinational read of the previous row's bit at a
// column, with the current row's bit written back to the same column.
module mask_line_buffer #(
  parameter int WIDTH = 720,
  parameter int AW    = $clog2(WIDTH)
) (
  input  logic          clk_in,
  input  logic          wr_en,
  input  logic [AW-1:0] addr,
  input  logic          wr_data,
  output logic          rd_data
);

  logic mem [WIDTH];
  logic in_range;

  // Columns beyond the row width never touch the array.
  assign in_range = (int'(addr) < WIDTH);
  assign rd_data  = in_range ? mem[addr] : 1'b0;

  always_ff @(posedge clk_in) begin
    if (wr_en && in_range) begin
      mem[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/shape_measure.sv
// Streams a raster mask, accumulating object area and crack-edge perimeter,
// and hands each completed frame's totals to the circularity stage.
//
// state   | meaning
// IDLE    | no result waiting for handoff
// PENDING | result latched, waiting for busy_in low
// ISSUE   | data_valid_out strobe cycle
module shape_measure
  import shape_pkg::*;
#(
  parameter  int WIDTH  = DEFAULT_WIDTH,
  parameter  int HEIGHT = DEFAULT_HEIGHT,
  localparam int CW     = calc_cw(WIDTH, HEIGHT),
  localparam int HW     = $clog2(WIDTH),
  localparam int VW     = $clog2(HEIGHT)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          pixel_valid_in,
  input  logic [HW-1:0] hcount_in,
  input  logic [VW-1:0] vcount_in,
  input  logic          mask_in,
  input  logic          busy_in,
  output logic [CW-1:0] area_out,
  output logic [CW-1:0] perimeter_out,
  output logic          data_valid_out,
  output logic          overrun_out
);

  localparam logic [HW-1:0] H_LAST = HW'(WIDTH - 1);
  localparam logic [VW-1:0] V_LAST = VW'(HEIGHT - 1);

  report_state_t state_q, state_d;

  logic [CW-1:0] area_acc, perim_acc;
  logic [CW-1:0] area_nxt, perim_nxt;
  logic [CW:0]   perim_sum;
  logic [2:0]    pc;
  logic          left_q, armed_q;
  logic          up_rd, left_eff, up_eff;
  logic          first_px, h_last, v_last, frame_end;

  mask_line_buffer #(
    .WIDTH (WIDTH),
    .AW    (HW)
  ) u_line_buffer (
    .clk_in  (clk_in),
    .wr_en   (pixel_valid_in),
    .addr    (hcount_in),
    .wr_data (mask_in),
    .rd_data (up_rd)
  );

  always_comb begin
    first_px  = pixel_valid_in && (hcount_in == '0) && (vcount_in == '0);
    h_last    = (hcount_in == H_LAST);
    v_last    = (vcount_in == V_LAST);
    left_eff  = (hcount_in == '0) ? 1'b0 : left_q;
    // Row 0 never trusts the line buffer, so it needs no clearing.
    up_eff    = (vcount_in == '0) ? 1'b0 : up_rd;
    pc        = 3'(mask_in ^ left_eff) + 3'(mask_in ^ up_eff)
              + 3'(mask_in & h_last)   + 3'(mask_in & v_last);
    area_nxt  = (first_px ? '0 : area_acc) + CW'(mask_in);
    perim_sum = {1'b0, (first_px ? '0 : perim_acc)} + (CW + 1)'(pc);
    perim_nxt = perim_sum[CW] ? '1 : perim_sum[CW-1:0];
    // Only frames that began at (0,0) since reset are reportable.
    frame_end = pixel_valid_in && h_last && v_last && (armed_q || first_px);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      area_acc      <= '0;
      perim_acc     <= '0;
      left_q        <= 1'b0;
      armed_q       <= 1'b0;
      area_out      <= '0;
      perimeter_out <= '0;
      overrun_out   <= 1'b0;
    end else begin
      overrun_out <= frame_end && (state_q == PENDING);
      if (pixel_valid_in) begin
        area_acc  <= area_nxt;
        perim_acc <= perim_nxt;
        left_q    <= mask_in;
        if (frame_end) begin
          armed_q <= 1'b0;
        end else if (first_px) begin
          armed_q <= 1'b1;
        end
      end
      if (frame_end) begin
        area_out      <= area_nxt;
        perimeter_out <= perim_nxt;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    data_valid_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_end) state_d = PENDING;
      end
      PENDING: begin
        // A new frame end wins over handoff: the fresh result waits instead.
        if (!frame_end && !busy_in) state_d = ISSUE;
      end
      ISSUE: begin
        data_valid_out = 1'b1;
        state_d        = frame_end ? PENDING : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_shape_measure.sv
// Self-checking bench for shape_measure on an 8x6 frame: scoreboarded
// handoffs plus latency, busy back-pressure, overrun and reset scenarios.
module tb_shape_measure;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int N  = W * H;
  localparam int CW = shape_pkg::calc_cw(W, H);
  localparam int HW = $clog2(W);
  localparam int VW = $clog2(H);

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          pixel_valid_in = 1'b0;
  logic [HW-1:0] hcount_in = '0;
  logic [VW-1:0] vcount_in = '0;
  logic          mask_in = 1'b0;
  logic          busy_in = 1'b0;
  logic [CW-1:0] area_out, perimeter_out;
  logic          data_valid_out, overrun_out;

  typedef struct {
    int area;
    int perim;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   dv_count = 0;
  int   ov_count = 0;
  int   last_dv_cyc = -1;
  int   fe_cyc = 0;
  bit   prev_dv = 1'b0;

  shape_measure #(
    .WIDTH  (W),
    .HEIGHT (H)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .pixel_valid_in (pixel_valid_in),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .mask_in        (mask_in),
    .busy_in        (busy_in),
    .area_out       (area_out),
    .perimeter_out  (perimeter_out),
    .data_valid_out (data_valid_out),
    .overrun_out    (overrun_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc++;

  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (data_valid_out) begin
        dv_count++;
        last_dv_cyc = cyc;
        checks++;
        if (prev_dv) begin
          errors++;
          $display("FAIL strobe_width: data_valid_out high on consecutive cycles at cycle %0d", cyc);
        end
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_report: got area %0d perim %0d, required no report", area_out, perimeter_out);
        end else begin
          mon_e = sb_q.pop_front();
          if (area_out !== CW'(mon_e.area) || perimeter_out !== CW'(mon_e.perim)) begin
            errors++;
            $display("FAIL report_values: got area %0d perim %0d, required area %0d perim %0d",
                     area_out, perimeter_out, mon_e.area, mon_e.perim);
          end
        end
      end
      if (overrun_out) ov_count++;
    end
    prev_dv = data_valid_out;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [N-1:0] rect(input int x0, input int y0, input int x1, input int y1);
    logic [N-1:0] f = '0;
    for (int v = y0; v <= y1; v++)
      for (int h = x0; h <= x1; h++)
        f[v*W+h] = 1'b1;
    return f;
  endfunction

  // Count object pixel sides that face background or the frame border.
  function automatic int model_perim(input logic [N-1:0] f);
    int p = 0;
    for (int v = 0; v < H; v++)
      for (int h = 0; h < W; h++)
        if (f[v*W+h]) begin
          if (h == 0     || !f[v*W+h-1])   p++;
          if (h == W - 1 || !f[v*W+h+1])   p++;
          if (v == 0     || !f[(v-1)*W+h]) p++;
          if (v == H - 1 || !f[(v+1)*W+h]) p++;
        end
    return p;
  endfunction

  task automatic drive_pixel(input bit vld, input int h, input int v, input bit m);
    @(negedge clk_in);
    pixel_valid_in = vld;
    hcount_in      = HW'(h);
    vcount_in      = VW'(v);
    mask_in        = m;
  endtask

  task automatic drive_rows(input logic [N-1:0] f, input int r0, input int r1, input int gap_pct);
    for (int v = r0; v <= r1; v++)
      for (int h = 0; h < W; h++) begin
        while (int'($urandom_range(99)) < gap_pct)
          drive_pixel(1'b0, int'($urandom_range(W - 1)), int'($urandom_range(H - 1)), 1'($urandom_range(1)));
        drive_pixel(1'b1, h, v, f[v*W+h]);
        if (v == H - 1 && h == W - 1) fe_cyc = cyc;
      end
    @(negedge clk_in);
    pixel_valid_in = 1'b0;
  endtask

  task automatic push_exp(input int a, input int p);
    exp_t e;
    e.area  = a;
    e.perim = p;
    sb_q.push_back(e);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d reports outstanding, required 0", name, sb_q.size());
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    checks += 4;
    if (area_out !== '0)       begin errors++; $display("FAIL reset_area: got %0d, required 0", area_out); end
    if (perimeter_out !== '0)  begin errors++; $display("FAIL reset_perim: got %0d, required 0", perimeter_out); end
    if (data_valid_out !== 0)  begin errors++; $display("FAIL reset_dv: got %0b, required 0", data_valid_out); end
    if (overrun_out !== 0)     begin errors++; $display("FAIL reset_overrun: got %0b, required 0", overrun_out); end
    rst_in = 1'b0;
  endtask

  task automatic test_single();
    logic [N-1:0] f = '0;
    int d0 = dv_count;
    f[2*W+3] = 1'b1;
    push_exp(1, 4);
    drive_rows(f, 0, H - 1, 0);
    wait_drain(20, "single");
    checks += 2;
    if (last_dv_cyc != fe_cyc + 2) begin
      errors++;
      $display("FAIL single_latency: strobe at cycle %0d, required %0d", last_dv_cyc, fe_cyc + 2);
    end
    if (dv_count != d0 + 1) begin
      errors++;
      $display("FAIL single_count: %0d strobes, required 1", dv_count - d0);
    end
  endtask

  task automatic test_shapes();
    push_exp(9, 12);
    drive_rows(rect(2, 1, 4, 3), 0, H - 1, 0);
    wait_drain(20, "block3x3");
    push_exp(48, 28);
    drive_rows('1, 0, H - 1, 0);
    wait_drain(20, "all_ones");
    push_exp(0, 0);
    drive_rows('0, 0, H - 1, 0);
    wait_drain(20, "empty");
  endtask

  task automatic test_busy();
    int d0 = dv_count;
    int b;
    busy_in = 1'b1;
    drive_rows(rect(2, 1, 4, 3), 0, H - 1, 0);
    push_exp(9, 12);
    repeat (10) begin
      @(negedge clk_in);
      checks++;
      if (area_out !== CW'(9) || perimeter_out !== CW'(12)) begin
        errors++;
        $display("FAIL busy_hold: got area %0d perim %0d, required 9 12", area_out, perimeter_out);
      end
    end
    #1;
    checks++;
    if (dv_count != d0) begin
      errors++;
      $display("FAIL busy_no_strobe: %0d strobes while busy, required 0", dv_count - d0);
    end
    @(negedge clk_in);
    busy_in = 1'b0;
    b = cyc;
    wait_drain(10, "busy_release");
    checks += 2;
    if (last_dv_cyc != b + 1) begin
      errors++;
      $display("FAIL busy_latency: strobe at cycle %0d, required %0d", last_dv_cyc, b + 1);
    end
    @(negedge clk_in);
    if (area_out !== CW'(9) || perimeter_out !== CW'(12)) begin
      errors++;
      $display("FAIL busy_after_issue: got area %0d perim %0d, required 9 12", area_out, perimeter_out);
    end
  endtask

  task automatic test_overrun();
    logic [N-1:0] f = '0;
    int o0 = ov_count;
    int d0 = dv_count;
    f[2*W+3] = 1'b1;
    busy_in = 1'b1;
    drive_rows(rect(2, 1, 4, 3), 0, H - 1, 0);
    drive_rows(f, 0, H - 1, 0);
    push_exp(1, 4);
    repeat (3) @(negedge clk_in);
    #1;
    checks += 2;
    if (ov_count != o0 + 1) begin
      errors++;
      $display("FAIL overrun_pulses: got %0d, required 1", ov_count - o0);
    end
    if (area_out !== CW'(1) || perimeter_out !== CW'(4)) begin
      errors++;
      $display("FAIL overrun_values: got area %0d perim %0d, required 1 4", area_out, perimeter_out);
    end
    busy_in = 1'b0;
    wait_drain(10, "overrun");
    checks++;
    if (dv_count != d0 + 1) begin
      errors++;
      $display("FAIL overrun_strobes: got %0d, required 1", dv_count - d0);
    end
  endtask

  task automatic test_reset_mid();
    int d0 = dv_count;
    drive_rows(rect(2, 1, 4, 3), 0, 2, 0);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    checks += 4;
    if (area_out !== '0)      begin errors++; $display("FAIL midrst_area: got %0d, required 0", area_out); end
    if (perimeter_out !== '0) begin errors++; $display("FAIL midrst_perim: got %0d, required 0", perimeter_out); end
    if (data_valid_out !== 0) begin errors++; $display("FAIL midrst_dv: got %0b, required 0", data_valid_out); end
    if (overrun_out !== 0)    begin errors++; $display("FAIL midrst_overrun: got %0b, required 0", overrun_out); end
    @(negedge clk_in);
    rst_in = 1'b0;
    drive_rows(rect(2, 1, 4, 3), 3, H - 1, 0);
    repeat (6) @(negedge clk_in);
    #1;
    checks += 2;
    if (dv_count != d0) begin
      errors++;
      $display("FAIL midrst_partial_report: %0d strobes, required 0", dv_count - d0);
    end
    if (area_out !== '0) begin
      errors++;
      $display("FAIL midrst_partial_latch: got area %0d, required 0", area_out);
    end
    push_exp(9, 12);
    drive_rows(rect(2, 1, 4, 3), 0, H - 1, 0);
    wait_drain(20, "after_reset");
  endtask

  task automatic test_gaps();
    push_exp(9, 12);
    drive_rows(rect(2, 1, 4, 3), 0, H - 1, 30);
    wait_drain(20, "gaps");
  endtask

  task automatic test_random_frames();
    logic [N-1:0] f;
    for (int i = 0; i < 4; i++) begin
      f = N'({$urandom, $urandom});
      push_exp($countones(f), model_perim(f));
      drive_rows(f, 0, H - 1, 20);
      wait_drain(20, "random");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_shapes();
    test_busy();
    test_overrun();
    test_reset_mid();
    test_gaps();
    test_random_frames();
    repeat (4) @(negedge clk_in);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL final_queue: %0d reports outstanding, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
